// File: rtl/bpu_update_ctrl.sv
// bpu_update_ctrl
// Sequences writes into the branch predictor's pattern history table (PHT)
// and global history register (GHR). Out of reset it sweeps every PHT entry
// to INIT_VALUE. After the sweep it buffers execute-stage branch resolutions
// in a small FIFO and retires one 2-bit saturating counter update per
// non-stalled cycle.
//
// Ports
//   CLK, RST          clock, asynchronous active-high reset
//   BPU__Stall        freezes outputs, sweep and FIFO read side
//   Resolve_*         resolution handshake and payload from execute
//   PHT_Write_*       registered PHT write port
//   GHR_Write_*       registered GHR shift port
//   Init_Busy         high while the initial sweep runs
module bpu_update_ctrl #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned IDX_WIDTH  = 11,
  parameter logic [1:0]  INIT_VALUE = 2'b01
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 BPU__Stall,
  input  logic                 Resolve_Valid,
  input  logic [IDX_WIDTH-1:0] Resolve_Index,
  input  logic [1:0]           Resolve_Counter,
  input  logic                 Resolve_Taken,
  output logic                 Resolve_Ready,
  output logic [IDX_WIDTH-1:0] PHT_Write_Index,
  output logic [1:0]           PHT_Write_Data,
  output logic                 PHT_Write_En,
  output logic                 GHR_Write_Data,
  output logic                 GHR_Write_En,
  output logic                 Init_Busy
);

  localparam int unsigned          PTR_W     = $clog2(DEPTH);
  localparam int unsigned          ENT_W     = IDX_WIDTH + 3;
  localparam logic [PTR_W:0]       DEPTH_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX  = '1;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_WIDTH-1:0] sweep_q, sweep_d;

  logic [ENT_W-1:0]     fifo_mem [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]       count_q;
  logic                 full, empty, push, pop;

  logic [IDX_WIDTH-1:0] head_idx;
  logic [1:0]           head_ctr;
  logic                 head_taken;
  logic [1:0]           upd_ctr;

  logic [IDX_WIDTH-1:0] idx_d;
  logic [1:0]           data_d;
  logic                 pht_en_d, ghr_data_d, ghr_en_d;

  assign full          = (count_q == DEPTH_CNT);
  assign empty         = (count_q == '0);
  assign Resolve_Ready = (state_q == ST_RUN) & ~full;
  assign Init_Busy     = (state_q == ST_INIT);

  // FIFO write side ignores the stall; only the read side is frozen.
  assign push = Resolve_Valid & Resolve_Ready;
  assign pop  = ~BPU__Stall & (state_q == ST_RUN) & ~empty;

  assign {head_idx, head_ctr, head_taken} = fifo_mem[rd_ptr_q];

  always_comb begin
    upd_ctr = head_ctr;
    if (head_taken) begin
      if (head_ctr != 2'b11) upd_ctr = head_ctr + 2'd1;
    end else begin
      if (head_ctr != 2'b00) upd_ctr = head_ctr - 2'd1;
    end
  end

  always_comb begin
    state_d    = state_q;
    sweep_d    = sweep_q;
    idx_d      = PHT_Write_Index;
    data_d     = PHT_Write_Data;
    pht_en_d   = PHT_Write_En;
    ghr_data_d = GHR_Write_Data;
    ghr_en_d   = GHR_Write_En;
    if (!BPU__Stall) begin
      case (state_q)
        ST_INIT: begin
          idx_d    = sweep_q;
          data_d   = INIT_VALUE;
          pht_en_d = 1'b1;
          ghr_en_d = 1'b0;
          sweep_d  = sweep_q + 1'b1;
          if (sweep_q == LAST_IDX) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (!empty) begin
            idx_d      = head_idx;
            data_d     = upd_ctr;
            pht_en_d   = 1'b1;
            ghr_data_d = head_taken;
            ghr_en_d   = 1'b1;
          end else begin
            pht_en_d = 1'b0;
            ghr_en_d = 1'b0;
          end
        end
        default: state_d = ST_INIT;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q         <= ST_INIT;
      sweep_q         <= '0;
      PHT_Write_Index <= '0;
      PHT_Write_Data  <= '0;
      PHT_Write_En    <= 1'b0;
      GHR_Write_Data  <= 1'b0;
      GHR_Write_En    <= 1'b0;
    end else begin
      state_q         <= state_d;
      sweep_q         <= sweep_d;
      PHT_Write_Index <= idx_d;
      PHT_Write_Data  <= data_d;
      PHT_Write_En    <= pht_en_d;
      GHR_Write_Data  <= ghr_data_d;
      GHR_Write_En    <= ghr_en_d;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_ptr_q] <= {Resolve_Index, Resolve_Counter, Resolve_Taken};
  end

endmodule

// File: tb/tb_bpu_update_ctrl.sv
module tb_bpu_update_ctrl;

  localparam int N = 2048;

  logic        CLK, RST, BPU__Stall;
  logic        Resolve_Valid, Resolve_Taken, Resolve_Ready;
  logic [10:0] Resolve_Index, PHT_Write_Index;
  logic [1:0]  Resolve_Counter, PHT_Write_Data;
  logic        PHT_Write_En, GHR_Write_Data, GHR_Write_En, Init_Busy;

  bpu_update_ctrl #(
    .DEPTH(4),
    .IDX_WIDTH(11),
    .INIT_VALUE(2'b01)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .BPU__Stall(BPU__Stall),
    .Resolve_Valid(Resolve_Valid),
    .Resolve_Index(Resolve_Index),
    .Resolve_Counter(Resolve_Counter),
    .Resolve_Taken(Resolve_Taken),
    .Resolve_Ready(Resolve_Ready),
    .PHT_Write_Index(PHT_Write_Index),
    .PHT_Write_Data(PHT_Write_Data),
    .PHT_Write_En(PHT_Write_En),
    .GHR_Write_Data(GHR_Write_Data),
    .GHR_Write_En(GHR_Write_En),
    .Init_Busy(Init_Busy)
  );

  typedef struct {
    logic [10:0] idx;
    logic [1:0]  c;
    logic        t;
    logic [1:0]  exp_data;
  } vec_t;

  typedef struct {
    logic [10:0] idx;
    logic [1:0]  data;
    logic        t;
    int          exp_cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every GHR strobe on a non-stalled edge is an update.
  initial begin
    logic st, rs;
    exp_t e;
    forever begin
      @(posedge CLK);
      st = BPU__Stall;
      rs = RST;
      #1;
      if (!st && !rs && !RST && GHR_Write_En) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write: got idx %0h data %0h, required no write", PHT_Write_Index, PHT_Write_Data);
        end else begin
          e = sb.pop_front();
          check("sb_idx", PHT_Write_Index, e.idx);
          check("sb_data", PHT_Write_Data, e.data);
          check("sb_pht_en", PHT_Write_En, 1);
          check("sb_ghr_data", GHR_Write_Data, e.t);
          if (e.exp_cyc >= 0) check("sb_latency_cycle", cyc, e.exp_cyc);
        end
      end
    end
  end

  // Entered and left at a negedge; optional stall window counted in cycles.
  task automatic run_sweep(input string name, input int stall_start, input int stall_len);
    int    k = 0;
    int    errs = 0;
    int    limit = N + stall_len + 16;
    string first = "none";
    logic  stl;
    for (int c = 0; k < N && c < limit; c++) begin
      stl = (c >= stall_start) && (c < stall_start + stall_len);
      BPU__Stall = stl;
      @(posedge CLK);
      #1;
      if (stl) begin
        if (PHT_Write_Index !== 11'(k - 1) || PHT_Write_Data !== 2'b01 || PHT_Write_En !== 1'b1 ||
            GHR_Write_En !== 1'b0 || Init_Busy !== 1'b1 || Resolve_Ready !== 1'b0) begin
          if (errs == 0) first = $sformatf("stall c=%0d idx=%0h en=%0b", c, PHT_Write_Index, PHT_Write_En);
          errs++;
        end
      end else begin
        if (PHT_Write_Index !== 11'(k) || PHT_Write_Data !== 2'b01 || PHT_Write_En !== 1'b1 ||
            GHR_Write_En !== 1'b0 || Init_Busy !== (k != N - 1) || Resolve_Ready !== (k == N - 1)) begin
          if (errs == 0)
            first = $sformatf("k=%0d idx=%0h data=%0h en=%0b ghr_en=%0b busy=%0b rdy=%0b", k, PHT_Write_Index,
                              PHT_Write_Data, PHT_Write_En, GHR_Write_En, Init_Busy, Resolve_Ready);
          errs++;
        end
        k++;
      end
      @(negedge CLK);
    end
    BPU__Stall = 1'b0;
    checks++;
    if (errs != 0 || k != N) begin
      failures++;
      $display("FAIL %s: mismatches=%0d writes=%0d, required 0 and %0d; first %s", name, errs, k, N, first);
    end
  endtask

  vec_t tbl[8];
  vec_t burst[4];
  vec_t extra;

  initial begin
    exp_t  e;
    int    k;
    int    frozen_err;
    logic [15:0] snap;

    tbl[0] = '{11'h155, 2'd3, 1'b1, 2'd3};
    tbl[1] = '{11'h0AA, 2'd0, 1'b0, 2'd0};
    tbl[2] = '{11'h001, 2'd1, 1'b1, 2'd2};
    tbl[3] = '{11'h002, 2'd2, 1'b0, 2'd1};
    tbl[4] = '{11'h7FF, 2'd0, 1'b1, 2'd1};
    tbl[5] = '{11'h000, 2'd3, 1'b0, 2'd2};
    tbl[6] = '{11'h3C3, 2'd2, 1'b1, 2'd3};
    tbl[7] = '{11'h400, 2'd1, 1'b0, 2'd0};
    burst[0] = '{11'h010, 2'd0, 1'b1, 2'd1};
    burst[1] = '{11'h020, 2'd1, 1'b1, 2'd2};
    burst[2] = '{11'h030, 2'd3, 1'b0, 2'd2};
    burst[3] = '{11'h7F0, 2'd2, 1'b1, 2'd3};
    extra    = '{11'h555, 2'd1, 1'b1, 2'd2};

    RST = 1'b1;
    BPU__Stall = 1'b0;
    Resolve_Valid = 1'b0;
    Resolve_Index = '0;
    Resolve_Counter = '0;
    Resolve_Taken = 1'b0;

    repeat (3) @(negedge CLK);
    check("rst_index", PHT_Write_Index, 0);
    check("rst_data", PHT_Write_Data, 0);
    check("rst_pht_en", PHT_Write_En, 0);
    check("rst_ghr_data", GHR_Write_Data, 0);
    check("rst_ghr_en", GHR_Write_En, 0);
    check("rst_busy", Init_Busy, 1);
    check("rst_ready", Resolve_Ready, 0);

    RST = 1'b0;
    run_sweep("sweep_plain", N + 100, 0);
    check("post_sweep_busy", Init_Busy, 0);
    check("post_sweep_ready", Resolve_Ready, 1);

    // Back-to-back resolutions, each visible one cycle after its push.
    for (int i = 0; i < 8; i++) begin
      check("table_ready", Resolve_Ready, 1);
      Resolve_Valid = 1'b1;
      Resolve_Index = tbl[i].idx;
      Resolve_Counter = tbl[i].c;
      Resolve_Taken = tbl[i].t;
      e = '{tbl[i].idx, tbl[i].exp_data, tbl[i].t, cyc + 2};
      sb.push_back(e);
      @(negedge CLK);
    end
    Resolve_Valid = 1'b0;
    repeat (3) @(negedge CLK);
    check("table_drained", sb.size(), 0);
    check("idle_pht_en", PHT_Write_En, 0);
    check("idle_ghr_en", GHR_Write_En, 0);

    // Stalled burst: four accepted, outputs frozen, then drained in order.
    BPU__Stall = 1'b1;
    snap = {PHT_Write_Index, PHT_Write_Data, PHT_Write_En, GHR_Write_Data, GHR_Write_En};
    k = 0;
    frozen_err = 0;
    for (int c = 0; c < 10; c++) begin
      Resolve_Valid = 1'b1;
      Resolve_Index = (k < 4) ? burst[k].idx : extra.idx;
      Resolve_Counter = (k < 4) ? burst[k].c : extra.c;
      Resolve_Taken = (k < 4) ? burst[k].t : extra.t;
      if (Resolve_Ready) begin
        if (k < 4) e = '{burst[k].idx, burst[k].exp_data, burst[k].t, -1};
        else e = '{extra.idx, extra.exp_data, extra.t, -1};
        sb.push_back(e);
        k++;
      end
      @(posedge CLK);
      #1;
      if ({PHT_Write_Index, PHT_Write_Data, PHT_Write_En, GHR_Write_Data, GHR_Write_En} !== snap) frozen_err++;
      @(negedge CLK);
    end
    check("stall_accepted", k, 4);
    check("stall_ready_full", Resolve_Ready, 0);
    check("stall_frozen_cycles", frozen_err, 0);
    Resolve_Valid = 1'b0;
    BPU__Stall = 1'b0;
    for (int i = 0; i < sb.size(); i++) sb[i].exp_cyc = cyc + 1 + i;
    repeat (6) @(negedge CLK);
    check("burst_drained", sb.size(), 0);

    // Fill three entries under stall, then reset asynchronously mid-cycle.
    BPU__Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      Resolve_Valid = 1'b1;
      Resolve_Index = tbl[i].idx;
      Resolve_Counter = tbl[i].c;
      Resolve_Taken = tbl[i].t;
      @(negedge CLK);
    end
    Resolve_Valid = 1'b0;
    #2;
    RST = 1'b1;
    sb.delete();
    #1;
    check("async_rst_index", PHT_Write_Index, 0);
    check("async_rst_data", PHT_Write_Data, 0);
    check("async_rst_ghr_data", GHR_Write_Data, 0);
    check("async_rst_busy", Init_Busy, 1);
    check("async_rst_ready", Resolve_Ready, 0);
    repeat (2) @(negedge CLK);
    BPU__Stall = 1'b0;
    Resolve_Valid = 1'b1;
    Resolve_Index = 11'h2AB;
    Resolve_Counter = 2'd2;
    Resolve_Taken = 1'b1;
    RST = 1'b0;
    run_sweep("sweep_midstall", 1000, 3);
    Resolve_Valid = 1'b0;
    repeat (5) @(negedge CLK);
    check("final_pht_en", PHT_Write_En, 0);
    check("final_ghr_en", GHR_Write_En, 0);
    check("final_ready", Resolve_Ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
